// File: rtl/dm_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dm_write_buffer
// Description : Posted-write FIFO between the byte-enable stage and the data
//               memory port, with same-word lane merging and load hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              st_addr,
    input  logic [3:0]               st_byteen,
    input  logic [31:0]              st_wdata,
    input  logic                     ld_en,
    input  logic [31:0]              ld_addr,
    output logic                     stall,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              m_addr,
    output logic [3:0]               m_byteen,
    output logic [31:0]              m_wdata,
    output logic                     m_wvalid,
    input  logic                     m_wready
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] head_q, head_d;
    logic [c_PTR_W-1:0] tail_q, tail_d;
    logic [c_CNT_W-1:0] count_q, count_d;

    logic [29:0] waddr_q  [DEPTH];
    logic [29:0] waddr_d  [DEPTH];
    logic [3:0]  byteen_q [DEPTH];
    logic [3:0]  byteen_d [DEPTH];
    logic [31:0] data_q   [DEPTH];
    logic [31:0] data_d   [DEPTH];

    logic               w_wr_req;
    logic [c_PTR_W-1:0] w_last;
    logic               w_merge;
    logic               w_full;
    logic               w_stall_w;
    logic               w_ld_hit;
    logic               w_push;
    logic               w_do_merge;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_off;

    // Merge target is the newest entry; requiring two entries keeps the head
    // (possibly being presented to memory) out of reach.
    always_comb begin
        w_wr_req   = |st_byteen;
        w_last     = tail_q - c_PTR_W'(1);
        w_full     = (count_q == c_CNT_W'(DEPTH));
        w_merge    = w_wr_req && (count_q >= c_CNT_W'(2)) &&
                     (waddr_q[w_last] == st_addr[31:2]);
        w_stall_w  = w_wr_req && !w_merge && w_full;
        stall      = w_stall_w | w_ld_hit;
        w_push     = w_wr_req && !w_merge && !stall;
        w_do_merge = w_merge && !stall;
        w_pop      = (count_q != '0) && m_wready;
    end

    // An entry is live when its distance from head is below count.
    always_comb begin
        w_ld_hit = 1'b0;
        w_off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = c_PTR_W'(i) - head_q;
            if (ld_en && ({1'b0, w_off} < count_q) &&
                (waddr_q[i] == ld_addr[31:2])) begin
                w_ld_hit = 1'b1;
            end
        end
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        waddr_d  = waddr_q;
        byteen_d = byteen_q;
        data_d   = data_q;

        if (w_do_merge) begin
            byteen_d[w_last] = byteen_q[w_last] | st_byteen;
            for (int b = 0; b < 4; b++) begin
                if (st_byteen[b]) begin
                    data_d[w_last][8*b +: 8] = st_wdata[8*b +: 8];
                end
            end
        end

        if (w_push) begin
            waddr_d[tail_q]  = st_addr[31:2];
            byteen_d[tail_q] = st_byteen;
            data_d[tail_q]   = st_wdata;
            tail_d           = tail_q + c_PTR_W'(1);
        end

        if (w_pop) begin
            head_d = head_q + c_PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: outputs are gated by the valid count.
    always_ff @(posedge clk) begin
        waddr_q  <= waddr_d;
        byteen_q <= byteen_d;
        data_q   <= data_d;
    end

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign m_wvalid = !empty;
    assign m_addr   = m_wvalid ? {waddr_q[head_q], 2'b00} : 32'h0;
    assign m_byteen = m_wvalid ? byteen_q[head_q] : 4'h0;
    assign m_wdata  = m_wvalid ? data_q[head_q] : 32'h0;

endmodule
`default_nettype wire

// File: doc/dm_write_buffer.md
# dm_write_buffer

Posted-write buffer between the byte-enable stage and the data-memory port. It accepts stores as word address + 4-bit byte enable + lane-aligned write data, queues them in a small FIFO, and drains them to data memory over a valid/ready handshake. The pipeline only stalls when the buffer is full or a load hits a pending store. Same-word stores to the newest non-draining entry merge byte lanes instead of taking a new slot.

## Interface
- DEPTH, 4, number of entries (power of two, ≥2)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- st_addr  input  32  store byte address; bits [1:0] ignored, word address = st_addr[31:2]
- st_byteen  input  4  store lane enables; 4'b0000 means no store this cycle
- st_wdata  input  32  lane-aligned store data
- ld_en  input  1  a load is issued this cycle
- ld_addr  input  32  load byte address
- stall  output  1  combinational; freeze the issuing stage
- empty  output  1  registered-state derived; no valid entries
- count  output  $clog2(DEPTH)+1  number of valid entries
- m_addr  output  32  head entry word address, {addr[31:2],2'b00}
- m_byteen  output  4  head entry byte enables
- m_wdata  output  32  head entry data
- m_wvalid  output  1  head entry valid (= !empty)
- m_wready  input  1  memory accepts head this cycle

## Operation
- Storage: DEPTH entries {waddr[29:0], byteen[3:0], data[31:0]}, circular with head/tail pointers and count.
- wr_req = (st_byteen != 0).
- Merge: wr_req && count ≥ 2 && waddr of newest entry (tail-1) == st_addr[31:2]. Each lane i with st_byteen[i]=1 overwrites data byte i. Entry byteen |= st_byteen. No new slot is used. The head is never a merge target.
- Push: wr_req && !merge && count < DEPTH. The entry is written at tail and tail advances.
- stall_w = wr_req && !merge && count == DEPTH. A full buffer stalls even if a pop happens the same cycle. This is a deterministic rule.
- stall_ld = ld_en && some valid entry has waddr == ld_addr[31:2]. Lane overlap is not checked.
- stall = stall_w | stall_ld. While stall=1, nothing is pushed or merged.
- Pop: m_wvalid && m_wready. Head advances.
- Same-cycle push and pop with 0 < count < DEPTH: count is unchanged, and both pointers advance.
- Merge and pop in the same cycle are allowed. The merge target is tail-1 evaluated before the pop, and requires count ≥ 2, so it is never the popped head.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: count=0, empty=1, m_wvalid=0, head=tail=0. m_addr, m_byteen and m_wdata are 0. stall=0, given idle inputs.
- A pushed store becomes visible on m_* the cycle after acceptance if the buffer was empty. The minimum store-to-memory latency is 1 cycle.
- m_addr, m_byteen and m_wdata are stable while m_wvalid && !m_wready. The head is never merged, so it never changes while presented.
- Throughput: 1 push and 1 pop per cycle.
- stall is purely combinational from the inputs and the current state. The upstream stage holds its inputs while stall=1.
- Reset mid-drain: all pending entries are discarded, m_wvalid=0 next cycle, and memory sees no further transfer.
- count and empty update on the clock edge after the push/pop event.

## Test plan
- Reset then idle → count=0, empty=1, m_wvalid=0, stall=0 for 5 cycles.
- With m_wready=0, push 4 stores to 0x100, 0x104, 0x108, 0x10C (byteen 4'hF) → count=4.
  - 5th store to 0x200 gives stall=1 and count stays 4.
  - Raise m_wready for 1 cycle → head 0x100 drains, but the 5th store is still stalled that cycle.
  - The 5th store is accepted the next cycle → count=4.
- With m_wready=0, push sw 0x11111111 @0x10, then sb 0xAA @0x20 (lane0), then sb 0xBB @0x21 (byteen 4'b0010, data 0x0000BB00).
  - The last sb merges → count=2.
  - Drain → second transfer m_addr=0x20, m_byteen=4'b0011, m_wdata[15:0]=0xBBAA.
- With m_wready=0 and one entry @0x40, ld_en with ld_addr=0x42 → stall=1.
  - ld_addr=0x44 → stall=0.
  - After the entry drains, ld_addr=0x42 → stall=0.
- With m_wready held 1, issue stores every cycle for 10 cycles → count ≤1, 10 transfers in order, stall never asserted.
- With 3 entries pending, assert reset for 1 cycle mid-handshake → next cycle m_wvalid=0, count=0, no m_* transfer after reset.
